// File: rtl/bascomp_mem_pkg.sv
// Shared definitions for the basic-computer memory arbiter.
//   ADDR_W / DATA_W : geometry of the 4096x16 `memory` block
//   CNT_W           : width of the read-latency counter (READ_LAT up to 4)
//   state_t         : arbiter FSM encoding
//   REQ_CPU/REQ_DMA : requester ids used for grant_id and the rr pointer
package bascomp_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between CPU and DMA.
//   clk, rst          : clock, synchronous active-high reset
//   cpu_req, dma_req  : raw request lines
//   grant_en          : high while the caller can accept a grant (FSM idle)
//   any_req           : at least one request pending
//   winner            : selected requester id (combinational)
// The pointer names the preferred requester. After every grant it points
// at the requester that did NOT win, so a waiting requester never loses
// more than one access to the other.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic grant_en,
  output logic any_req,
  output logic winner
);
  import bascomp_mem_pkg::*;

  logic pref_q;

  assign any_req = cpu_req | dma_req;

  always_comb begin
    winner = pref_q;
    if (cpu_req && !dma_req)      winner = REQ_CPU;
    else if (dma_req && !cpu_req) winner = REQ_DMA;
  end

  always_ff @(posedge clk) begin
    if (rst)                      pref_q <= REQ_CPU;
    else if (grant_en && any_req) pref_q <= ~winner;
  end

endmodule

// File: rtl/mem_arbiter.sv
// CPU / DMA controller for the single-port 4096x16 `memory` block.
// Every access runs IDLE -> ACCESS -> [WAIT] -> RESP with fixed latency;
// the winner gets a one-cycle ack and, for reads, its rdata register.
//   clk, rst                      : clock, synchronous active-high reset
//   cpu_* / dma_*                 : requester ports (req/we/adress/wdata in,
//                                   ack/rdata out)
//   adress, read, write, indata   : command to `memory` (sole driver)
//   outdata                       : read data from `memory`
//   busy                          : FSM not idle
//   grant_id                      : requester currently or last served
// All outputs are registered.
module mem_arbiter #(
  parameter int ADDR_W   = bascomp_mem_pkg::ADDR_W,
  parameter int DATA_W   = bascomp_mem_pkg::DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adress,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_adress,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] adress,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] indata,
  input  logic [DATA_W-1:0] outdata,
  output logic              busy,
  output logic              grant_id
);
  import bascomp_mem_pkg::*;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic               any_req, winner;

  logic [ADDR_W-1:0]  adress_d;
  logic [DATA_W-1:0]  indata_d, cpu_rdata_d, dma_rdata_d;
  logic               read_d, write_d, busy_d, grant_d;
  logic               cpu_ack_d, dma_ack_d;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .grant_en (state_q == ST_IDLE),
    .any_req  (any_req),
    .winner   (winner)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_ACCESS;
      ST_ACCESS: state_d = we_q ? ST_RESP : ST_WAIT;
      ST_WAIT:   if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // next values of the registered outputs; address/data hold after grant
  // so requester-side changes cannot disturb an access in flight
  always_comb begin
    adress_d    = adress;
    indata_d    = indata;
    we_d        = we_q;
    grant_d     = grant_id;
    busy_d      = busy;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata;
    dma_rdata_d = dma_rdata;
    read_d      = 1'b0;
    write_d     = 1'b0;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          adress_d = (winner == REQ_DMA) ? dma_adress : cpu_adress;
          indata_d = (winner == REQ_DMA) ? dma_wdata  : cpu_wdata;
          we_d     = (winner == REQ_DMA) ? dma_we     : cpu_we;
          write_d  = we_d;
          read_d   = ~we_d;
          grant_d  = winner;
          busy_d   = 1'b1;
        end
      end
      ST_ACCESS: begin
        // memory samples the command at this closing edge
        cnt_d = CNT_W'(READ_LAT);
        if (we_q) begin
          if (grant_id == REQ_DMA) dma_ack_d = 1'b1;
          else                     cpu_ack_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          if (grant_id == REQ_DMA) begin
            dma_rdata_d = outdata;
            dma_ack_d   = 1'b1;
          end else begin
            cpu_rdata_d = outdata;
            cpu_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: busy_d = 1'b0;
      default: busy_d = 1'b0;
    endcase
  end

  // output / datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      adress    <= '0;
      indata    <= '0;
      read      <= 1'b0;
      write     <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      busy      <= 1'b0;
      grant_id  <= REQ_CPU;
      we_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      adress    <= adress_d;
      indata    <= indata_d;
      read      <= read_d;
      write     <= write_d;
      cpu_ack   <= cpu_ack_d;
      dma_ack   <= dma_ack_d;
      cpu_rdata <= cpu_rdata_d;
      dma_rdata <= dma_rdata_d;
      busy      <= busy_d;
      grant_id  <= grant_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
